// File: rtl/axi_arb2_if.sv
// AXI bus bundle shared by the two-port arbiter and its neighbours.
// Modport names describe what the port faces:
//   master - the port faces an upstream AXI master, so requests (AW/W/AR)
//            arrive as inputs and responses (B/R) leave as outputs.
//   slave  - the port faces a downstream AXI slave, so requests leave as
//            outputs and responses arrive as inputs.
interface axi_bus_t;
    logic [15:0] awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [15:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [15:0] arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [15:0] rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport slave (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_arb2.sv
// Two-to-one AXI arbiter. AW and AR are granted round-robin with a grant
// lock that holds the selection stable while the downstream stalls. The
// granted port number is carried in ID bit 15 downstream, so B and R route
// back without any per-transaction tracking. W beats follow AW grant order
// through a small write-order FIFO of port bits.
module axi_arb2 #(
    parameter int WO_LD = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    axi_bus_t.master axi_s0,
    axi_bus_t.master axi_s1,
    axi_bus_t.slave  axi_m
);

    localparam int WO_DEPTH = 1 << WO_LD;

    // Pointer port wins if it is requesting, otherwise the other port.
    function automatic logic rr_pick(input logic ptr, input logic v0, input logic v1);
        return ptr ? v1 : ~v0;
    endfunction

    // ------------------------------------------------------------------
    // AR channel
    // ------------------------------------------------------------------
    logic ar_ptr;
    logic ar_lock;
    logic ar_lock_port;
    logic ar_sel;
    logic ar_hs;

    assign ar_sel = ar_lock ? ar_lock_port
                            : rr_pick(ar_ptr, axi_s0.arvalid, axi_s1.arvalid);

    assign axi_m.arvalid = axi_s0.arvalid | axi_s1.arvalid;
    assign axi_m.arid    = {ar_sel, ar_sel ? axi_s1.arid[14:0] : axi_s0.arid[14:0]};
    assign axi_m.araddr  = ar_sel ? axi_s1.araddr  : axi_s0.araddr;
    assign axi_m.arlen   = ar_sel ? axi_s1.arlen   : axi_s0.arlen;
    assign axi_m.arsize  = ar_sel ? axi_s1.arsize  : axi_s0.arsize;
    assign axi_m.arburst = ar_sel ? axi_s1.arburst : axi_s0.arburst;

    assign ar_hs = axi_m.arvalid & axi_m.arready;

    assign axi_s0.arready = ar_hs & ~ar_sel & axi_s0.arvalid;
    assign axi_s1.arready = ar_hs &  ar_sel & axi_s1.arvalid;

    // AR grant lock while stalled; rotate the pointer past the winner on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_ptr       <= 1'b0;
            ar_lock      <= 1'b0;
            ar_lock_port <= 1'b0;
        end else if (ar_hs) begin
            ar_lock <= 1'b0;
            ar_ptr  <= ~ar_sel;
        end else if (axi_m.arvalid) begin
            ar_lock      <= 1'b1;
            ar_lock_port <= ar_sel;
        end
    end

    // ------------------------------------------------------------------
    // Write-order FIFO: one port bit per granted AW whose W burst is open
    // ------------------------------------------------------------------
    logic [WO_LD:0] wo_wr;
    logic [WO_LD:0] wo_rd;
    logic           wo_mem [WO_DEPTH];
    logic           wo_empty;
    logic           wo_full;
    logic           wo_head;
    logic           wo_push;
    logic           wo_pop;

    assign wo_empty = (wo_wr == wo_rd);
    assign wo_full  = (wo_wr[WO_LD] != wo_rd[WO_LD]) &&
                      (wo_wr[WO_LD-1:0] == wo_rd[WO_LD-1:0]);
    assign wo_head  = wo_mem[wo_rd[WO_LD-1:0]];

    // ------------------------------------------------------------------
    // AW channel
    // ------------------------------------------------------------------
    logic aw_ptr;
    logic aw_lock;
    logic aw_lock_port;
    logic aw_sel;
    logic aw_any;
    logic aw_hs;

    assign aw_any = axi_s0.awvalid | axi_s1.awvalid;
    assign aw_sel = aw_lock ? aw_lock_port
                            : rr_pick(aw_ptr, axi_s0.awvalid, axi_s1.awvalid);

    // A full order FIFO holds the AW back; nothing else would remember which
    // port owns the next W burst.
    assign axi_m.awvalid = aw_any & ~wo_full;
    assign axi_m.awid    = {aw_sel, aw_sel ? axi_s1.awid[14:0] : axi_s0.awid[14:0]};
    assign axi_m.awaddr  = aw_sel ? axi_s1.awaddr  : axi_s0.awaddr;
    assign axi_m.awlen   = aw_sel ? axi_s1.awlen   : axi_s0.awlen;
    assign axi_m.awsize  = aw_sel ? axi_s1.awsize  : axi_s0.awsize;
    assign axi_m.awburst = aw_sel ? axi_s1.awburst : axi_s0.awburst;

    assign aw_hs = axi_m.awvalid & axi_m.awready;

    assign axi_s0.awready = aw_hs & ~aw_sel & axi_s0.awvalid;
    assign axi_s1.awready = aw_hs &  aw_sel & axi_s1.awvalid;

    // AW grant lock; also taken while blocked on a full FIFO so the grant
    // cannot move under a waiting request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_ptr       <= 1'b0;
            aw_lock      <= 1'b0;
            aw_lock_port <= 1'b0;
        end else if (aw_hs) begin
            aw_lock <= 1'b0;
            aw_ptr  <= ~aw_sel;
        end else if (aw_any) begin
            aw_lock      <= 1'b1;
            aw_lock_port <= aw_sel;
        end
    end

    // ------------------------------------------------------------------
    // W steering
    // ------------------------------------------------------------------
    assign axi_m.wdata  = wo_head ? axi_s1.wdata : axi_s0.wdata;
    assign axi_m.wstrb  = wo_head ? axi_s1.wstrb : axi_s0.wstrb;
    assign axi_m.wlast  = wo_head ? axi_s1.wlast : axi_s0.wlast;
    assign axi_m.wvalid = ~wo_empty & (wo_head ? axi_s1.wvalid : axi_s0.wvalid);

    assign axi_s0.wready = ~wo_empty & ~wo_head & axi_m.wready;
    assign axi_s1.wready = ~wo_empty &  wo_head & axi_m.wready;

    assign wo_push = aw_hs;
    assign wo_pop  = axi_m.wvalid & axi_m.wready & axi_m.wlast;

    // Order FIFO pointers; push and pop in one cycle leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wo_wr <= '0;
            wo_rd <= '0;
        end else begin
            if (wo_push) begin
                wo_wr <= wo_wr + 1'b1;
            end
            if (wo_pop) begin
                wo_rd <= wo_rd + 1'b1;
            end
        end
    end

    // Order FIFO storage: record the granted port at the write slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WO_DEPTH; i++) begin
                wo_mem[i] <= 1'b0;
            end
        end else if (wo_push) begin
            wo_mem[wo_wr[WO_LD-1:0]] <= aw_sel;
        end
    end

    // ------------------------------------------------------------------
    // B routing by returned ID tag
    // ------------------------------------------------------------------
    logic b_port;

    assign b_port = axi_m.bid[15];

    assign axi_s0.bid    = {1'b0, axi_m.bid[14:0]};
    assign axi_s1.bid    = {1'b0, axi_m.bid[14:0]};
    assign axi_s0.bresp  = axi_m.bresp;
    assign axi_s1.bresp  = axi_m.bresp;
    assign axi_s0.bvalid = axi_m.bvalid & ~b_port;
    assign axi_s1.bvalid = axi_m.bvalid &  b_port;
    assign axi_m.bready  = b_port ? axi_s1.bready : axi_s0.bready;

    // ------------------------------------------------------------------
    // R routing by returned ID tag
    // ------------------------------------------------------------------
    logic r_port;

    assign r_port = axi_m.rid[15];

    assign axi_s0.rid    = {1'b0, axi_m.rid[14:0]};
    assign axi_s1.rid    = {1'b0, axi_m.rid[14:0]};
    assign axi_s0.rdata  = axi_m.rdata;
    assign axi_s1.rdata  = axi_m.rdata;
    assign axi_s0.rresp  = axi_m.rresp;
    assign axi_s1.rresp  = axi_m.rresp;
    assign axi_s0.rlast  = axi_m.rlast;
    assign axi_s1.rlast  = axi_m.rlast;
    assign axi_s0.rvalid = axi_m.rvalid & ~r_port;
    assign axi_s1.rvalid = axi_m.rvalid &  r_port;
    assign axi_m.rready  = r_port ? axi_s1.rready : axi_s0.rready;

endmodule

// File: tb/tb_axi_arb2.sv
// Self-checking bench for axi_arb2 (order FIFO depth 2). Expected downstream
// AR/AW/W and upstream B/R handshakes are queued as stimulus is driven and
// popped by monitors on the falling edge.
module tb_axi_arb2;

    logic clk;
    logic rst_n;

    axi_bus_t s0 ();
    axi_bus_t s1 ();
    axi_bus_t m ();

    axi_arb2 #(.WO_LD(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .axi_s0 (s0),
        .axi_s1 (s1),
        .axi_m  (m)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [47:0] ar_q [$];
    logic [23:0] aw_q [$];
    logic [32:0] w_q  [$];
    logic [18:0] b_q  [$];
    logic [49:0] r_q  [$];

    int n_gnt0 = 0;
    int n_gnt1 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        s0.awid = '0; s0.awaddr = '0; s0.awlen = '0; s0.awsize = 3'd2; s0.awburst = 2'd1; s0.awvalid = 1'b0;
        s1.awid = '0; s1.awaddr = '0; s1.awlen = '0; s1.awsize = 3'd2; s1.awburst = 2'd1; s1.awvalid = 1'b0;
        s0.wdata = '0; s0.wstrb = 4'hf; s0.wlast = 1'b0; s0.wvalid = 1'b0;
        s1.wdata = '0; s1.wstrb = 4'hf; s1.wlast = 1'b0; s1.wvalid = 1'b0;
        s0.arid = '0; s0.araddr = '0; s0.arlen = '0; s0.arsize = 3'd2; s0.arburst = 2'd1; s0.arvalid = 1'b0;
        s1.arid = '0; s1.araddr = '0; s1.arlen = '0; s1.arsize = 3'd2; s1.arburst = 2'd1; s1.arvalid = 1'b0;
        s0.bready = 1'b0; s1.bready = 1'b0; s0.rready = 1'b0; s1.rready = 1'b0;
        m.awready = 1'b0; m.wready = 1'b0; m.arready = 1'b0;
        m.bid = '0; m.bresp = '0; m.bvalid = 1'b0;
        m.rid = '0; m.rdata = '0; m.rresp = '0; m.rlast = 1'b0; m.rvalid = 1'b0;
    endtask

    // Scoreboard monitors for every handshake seen this cycle.
    always @(negedge clk) begin
        if (m.arvalid && m.arready) begin
            chk("ar_sb_avail", ar_q.size() != 0, 1);
            if (ar_q.size() != 0) chk("ar_sb", {m.arid, m.araddr}, ar_q.pop_front());
            if (m.arid[15]) n_gnt1++; else n_gnt0++;
        end
        if (m.awvalid && m.awready) begin
            chk("aw_sb_avail", aw_q.size() != 0, 1);
            if (aw_q.size() != 0) chk("aw_sb", {m.awid, m.awlen}, aw_q.pop_front());
        end
        if (m.wvalid && m.wready) begin
            chk("w_sb_avail", w_q.size() != 0, 1);
            if (w_q.size() != 0) chk("w_sb", {m.wlast, m.wdata}, w_q.pop_front());
        end
        if (s0.bvalid && s0.bready) begin
            chk("b_sb_avail", b_q.size() != 0, 1);
            if (b_q.size() != 0) chk("b_sb", {1'b0, s0.bid, s0.bresp}, b_q.pop_front());
        end
        if (s1.bvalid && s1.bready) begin
            chk("b_sb_avail", b_q.size() != 0, 1);
            if (b_q.size() != 0) chk("b_sb", {1'b1, s1.bid, s1.bresp}, b_q.pop_front());
        end
        if (s0.rvalid && s0.rready) begin
            chk("r_sb_avail", r_q.size() != 0, 1);
            if (r_q.size() != 0) chk("r_sb", {1'b0, s0.rid, s0.rdata, s0.rlast}, r_q.pop_front());
        end
        if (s1.rvalid && s1.rready) begin
            chk("r_sb_avail", r_q.size() != 0, 1);
            if (r_q.size() != 0) chk("r_sb", {1'b1, s1.rid, s1.rdata, s1.rlast}, r_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int g0;
        int g1;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle_all();
        m.wready  = 1'b1;
        s0.wvalid = 1'b1;
        #1;
        chk("rst_arvalid", m.arvalid, 0);
        chk("rst_awvalid", m.awvalid, 0);
        chk("rst_wvalid", m.wvalid, 0);
        chk("rst_s0_wready", s0.wready, 0);
        chk("rst_s1_wready", s1.wready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_all();
        rst_n = 1'b1;
        tick();

        // ---------------- AR lock while stalled ----------------
        s0.arvalid = 1'b1; s0.arid = 16'h0005; s0.araddr = 32'h1000;
        ar_q.push_back({16'h0005, 32'h1000});
        ar_q.push_back({16'h8007, 32'h2000});
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                s1.arvalid = 1'b1; s1.arid = 16'h0007; s1.araddr = 32'h2000;
            end
            m.arready = (c == 3);
            @(negedge clk);
            chk("ar_lock_id", m.arid, 16'h0005);
            chk("ar_lock_addr", m.araddr, 32'h1000);
            chk("ar_s0_ready", s0.arready, (c == 3));
            chk("ar_s1_ready", s1.arready, 0);
            tick();
        end
        s0.arvalid = 1'b0;
        @(negedge clk);
        chk("ar_ptr1_id", m.arid, 16'h8007);
        chk("ar_ptr1_rdy", s1.arready, 1);
        tick();
        s1.arvalid = 1'b0;

        // ---------------- AR round-robin, both ports busy ----------------
        g0 = n_gnt0;
        g1 = n_gnt1;
        s0.arvalid = 1'b1; s0.arid = 16'h8011; s0.araddr = 32'h3000;
        s1.arvalid = 1'b1; s1.arid = 16'h8022; s1.araddr = 32'h4000;
        m.arready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) ar_q.push_back({16'h0011, 32'h3000});
            else            ar_q.push_back({16'h8022, 32'h4000});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_s0_gnt", s0.arready, (i % 2 == 0));
            chk("rr_s1_gnt", s1.arready, (i % 2 == 1));
            tick();
        end
        s0.arvalid = 1'b0; s1.arvalid = 1'b0; m.arready = 1'b0;
        chk("rr_cnt0", n_gnt0 - g0, 4);
        chk("rr_cnt1", n_gnt1 - g1, 4);

        // ---------------- W follows AW grant order ----------------
        m.awready = 1'b1; m.wready = 1'b1;
        s1.awvalid = 1'b1; s1.awid = 16'h0001; s1.awlen = 8'd3;
        s0.wvalid = 1'b1; s0.wdata = 32'hA0; s0.wlast = 1'b0;
        aw_q.push_back({16'h8001, 8'd3});
        @(negedge clk);
        chk("w_before_aw", m.wvalid, 0);
        chk("w_before_aw_rdy", s0.wready, 0);
        tick();
        s1.awvalid = 1'b0;
        s0.awvalid = 1'b1; s0.awid = 16'h0002; s0.awlen = 8'd1;
        aw_q.push_back({16'h0002, 8'd1});
        @(negedge clk);
        chk("w_order_rdy", s0.wready, 0);
        chk("w_order_valid", m.wvalid, 0);
        tick();
        s0.awvalid = 1'b0;
        for (int b = 0; b < 4; b++) w_q.push_back({(b == 3), 32'hB0 + b});
        for (int b = 0; b < 2; b++) w_q.push_back({(b == 1), 32'hA0 + b});
        for (int b = 0; b < 4; b++) begin
            s1.wvalid = 1'b1; s1.wdata = 32'hB0 + b; s1.wlast = (b == 3);
            @(negedge clk);
            chk("w_hold_p0", s0.wready, 0);
            chk("w_p1_rdy", s1.wready, 1);
            tick();
        end
        s1.wvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s0.wdata = 32'hA0 + b; s0.wlast = (b == 1);
            @(negedge clk);
            chk("w_p0_rdy", s0.wready, 1);
            tick();
        end
        s0.wvalid = 1'b1; s0.wdata = 32'hEE; s0.wlast = 1'b1;
        @(negedge clk);
        chk("w_empty_valid", m.wvalid, 0);
        chk("w_empty_rdy", s0.wready, 0);
        tick();
        s0.wvalid = 1'b0; s0.wlast = 1'b0;
        m.awready = 1'b0; m.wready = 1'b0;

        // ---------------- B and R routing ----------------
        m.bvalid = 1'b1; m.bid = 16'h0004; m.bresp = 2'b01;
        s0.bready = 1'b0; s1.bready = 1'b1;
        b_q.push_back({1'b0, 16'h0004, 2'b01});
        @(negedge clk);
        chk("b_route0", s0.bvalid, 1);
        chk("b_other0", s1.bvalid, 0);
        chk("b_id0", s0.bid, 16'h0004);
        chk("b_ready_hold", m.bready, 0);
        tick();
        s0.bready = 1'b1;
        @(negedge clk);
        chk("b_ready_pass", m.bready, 1);
        tick();
        m.bid = 16'h8009; m.bresp = 2'b00;
        b_q.push_back({1'b1, 16'h0009, 2'b00});
        @(negedge clk);
        chk("b_route1", s1.bvalid, 1);
        chk("b_other1", s0.bvalid, 0);
        tick();
        m.bvalid = 1'b0; s0.bready = 1'b0; s1.bready = 1'b0;

        m.rvalid = 1'b1; m.rid = 16'h8003; m.rdata = 32'hDEADBEEF; m.rlast = 1'b1; m.rresp = 2'b00;
        s1.rready = 1'b0; s0.rready = 1'b1;
        r_q.push_back({1'b1, 16'h0003, 32'hDEADBEEF, 1'b1});
        @(negedge clk);
        chk("r_route1", s1.rvalid, 1);
        chk("r_id1", s1.rid, 16'h0003);
        chk("r_other", s0.rvalid, 0);
        chk("r_ready_hold", m.rready, 0);
        tick();
        s1.rready = 1'b1;
        @(negedge clk);
        chk("r_ready_pass", m.rready, 1);
        tick();
        m.rvalid = 1'b0; m.rlast = 1'b0; s0.rready = 1'b0; s1.rready = 1'b0;

        // ---------------- AW blocked on full order FIFO ----------------
        m.awready = 1'b1; m.wready = 1'b0;
        s0.awvalid = 1'b1; s0.awid = 16'h0010; s0.awlen = 8'd0;
        aw_q.push_back({16'h0010, 8'd0});
        aw_q.push_back({16'h0011, 8'd0});
        aw_q.push_back({16'h0012, 8'd0});
        aw_q.push_back({16'h8013, 8'd0});
        @(negedge clk);
        chk("full_aw0", s0.awready, 1);
        tick();
        s0.awid = 16'h0011;
        @(negedge clk);
        chk("full_aw1", s0.awready, 1);
        tick();
        s0.awid = 16'h0012;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                s1.awvalid = 1'b1; s1.awid = 16'h0013; s1.awlen = 8'd0;
            end
            @(negedge clk);
            chk("full_awvalid", m.awvalid, 0);
            chk("full_s0_rdy", s0.awready, 0);
            chk("full_s1_rdy", s1.awready, 0);
            chk("full_hold_id", m.awid, 16'h0012);
            tick();
        end
        w_q.push_back({1'b1, 32'hC0});
        w_q.push_back({1'b1, 32'hC1});
        w_q.push_back({1'b1, 32'hC2});
        w_q.push_back({1'b1, 32'hD0});
        s0.wvalid = 1'b1; s0.wdata = 32'hC0; s0.wlast = 1'b1; m.wready = 1'b1;
        @(negedge clk);
        chk("full_pop_awvalid", m.awvalid, 0);
        chk("full_pop_rdy", s0.wready, 1);
        tick();
        s0.wdata = 32'hC1;
        @(negedge clk);
        chk("full_resume", m.awvalid, 1);
        chk("full_resume_id", m.awid, 16'h0012);
        chk("full_resume_rdy", s0.awready, 1);
        tick();
        s0.awvalid = 1'b0; s0.wdata = 32'hC2;
        @(negedge clk);
        chk("full_next_id", m.awid, 16'h8013);
        chk("full_next_rdy", s1.awready, 1);
        tick();
        s1.awvalid = 1'b0; s0.wvalid = 1'b0;
        s1.wvalid = 1'b1; s1.wdata = 32'hD0; s1.wlast = 1'b1;
        @(negedge clk);
        chk("full_p1_wrdy", s1.wready, 1);
        tick();
        s1.wvalid = 1'b0; s1.wlast = 1'b0;
        @(negedge clk);
        chk("full_drained", m.wvalid, 0);
        tick();

        // ---------------- reset mid-burst with a locked AR ----------------
        m.arready = 1'b1;
        s0.arvalid = 1'b1; s0.arid = 16'h0030; s0.araddr = 32'h5000;
        ar_q.push_back({16'h0030, 32'h5000});
        @(negedge clk);
        tick();
        s0.arvalid = 1'b0; m.arready = 1'b0;
        s1.arvalid = 1'b1; s1.arid = 16'h0031; s1.araddr = 32'h6000;
        s0.awvalid = 1'b1; s0.awid = 16'h0040; s0.awlen = 8'd3;
        aw_q.push_back({16'h0040, 8'd3});
        @(negedge clk);
        tick();
        s0.awvalid = 1'b0;
        s0.wvalid = 1'b1; s0.wdata = 32'hE0; s0.wlast = 1'b0;
        w_q.push_back({1'b0, 32'hE0});
        @(negedge clk);
        chk("mid_w_rdy", s0.wready, 1);
        tick();
        s0.wdata = 32'hE1;
        #2;
        rst_n = 1'b0;
        s1.arvalid = 1'b0;
        #1;
        chk("arst_wvalid", m.wvalid, 0);
        chk("arst_wready", s0.wready, 0);
        chk("arst_arvalid", m.arvalid, 0);
        chk("arst_awvalid", m.awvalid, 0);
        chk("arst_arready", s1.arready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wo_empty", s0.wready, 0);
        chk("post_rst_wvalid", m.wvalid, 0);
        tick();
        s0.wvalid = 1'b0;
        m.arready = 1'b1;
        s0.arvalid = 1'b1; s0.arid = 16'h0050; s0.araddr = 32'h7000;
        s1.arvalid = 1'b1; s1.arid = 16'h0051; s1.araddr = 32'h8000;
        ar_q.push_back({16'h0050, 32'h7000});
        ar_q.push_back({16'h8051, 32'h8000});
        @(negedge clk);
        chk("post_rst_prio", s0.arready, 1);
        chk("post_rst_id", m.arid, 16'h0050);
        tick();
        s0.arvalid = 1'b0;
        @(negedge clk);
        tick();
        idle_all();
        tick();

        chk("ar_q_left", ar_q.size(), 0);
        chk("aw_q_left", aw_q.size(), 0);
        chk("w_q_left", w_q.size(), 0);
        chk("b_q_left", b_q.size(), 0);
        chk("r_q_left", r_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
